// File: rtl/mem_stage_ctl.sv
// MEM-stage controller: drives a handshaked data memory and registers the MEM/WB bundle.
// Non-memory ops take 1 cycle; accesses take 2+wait cycles with stall held until the ack cycle.
module mem_stage_ctl #(
    parameter int IN_W  = 142,
    parameter int OUT_W = 71
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:IN_W-1]  exmem_in,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [0:31]      dmem_addr,
    output logic [0:3]       dmem_be,
    output logic [0:31]      dmem_wdata,
    input  logic [0:31]      dmem_rdata,
    input  logic             dmem_ack,
    output logic             stall,
    output logic             align_err,
    output logic [0:OUT_W-1] memwb_out
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t r_state;
    state_t w_next_state;

    logic [0:31] w_next_pc;
    logic [0:31] w_opb;
    logic [0:4]  w_dest;
    logic [0:31] w_alu;
    logic        w_pc_to_reg;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_load_sign;
    logic [1:0]  w_dsize;
    logic [0:31] w_leap_addr;
    logic        w_leap;
    logic        w_unused_regtopc;

    assign w_next_pc        = exmem_in[0:31];
    assign w_opb            = exmem_in[32:63];
    assign w_dest           = exmem_in[64:68];
    assign w_alu            = exmem_in[69:100];
    assign w_pc_to_reg      = exmem_in[101];
    assign w_unused_regtopc = exmem_in[102];
    assign w_reg_write      = exmem_in[103];
    assign w_mem_to_reg     = exmem_in[104];
    assign w_mem_write      = exmem_in[105];
    assign w_load_sign      = exmem_in[106];
    assign w_dsize          = exmem_in[107:108];
    assign w_leap_addr      = exmem_in[109:140];
    assign w_leap           = exmem_in[141];

    logic [1:0] w_off;
    logic       w_is_byte;
    logic       w_is_half;
    logic       w_is_word;
    logic       w_memop;
    logic       w_misaligned;

    assign w_off        = w_alu[30:31];
    assign w_is_byte    = (w_dsize == 2'b00);
    assign w_is_half    = (w_dsize == 2'b01);
    assign w_is_word    = w_dsize[1];
    assign w_memop      = w_mem_to_reg | w_mem_write;
    assign w_misaligned = w_memop & ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));

    logic [0:3]  w_be;
    logic [0:31] w_wdata;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_opb;
        if (w_is_byte) begin
            w_be[w_off] = 1'b1;
            w_wdata     = {4{w_opb[24:31]}};
        end else if (w_is_half) begin
            w_be    = w_off[1] ? 4'b0011 : 4'b1100;
            w_wdata = {2{w_opb[16:31]}};
        end else begin
            w_be = 4'b1111;
        end
    end

    // Lane select assumes big-endian lane numbering: offset 0 is rdata[0:7].
    logic [0:7]  w_ld_byte;
    logic [0:15] w_ld_half;
    logic [0:31] w_load;

    assign w_ld_byte = dmem_rdata[{w_off, 3'b000} +: 8];
    assign w_ld_half = w_off[1] ? dmem_rdata[16:31] : dmem_rdata[0:15];

    always_comb begin
        w_load = dmem_rdata;
        if (w_is_byte) begin
            w_load = {{24{w_load_sign & w_ld_byte[0]}}, w_ld_byte};
        end else if (w_is_half) begin
            w_load = {{16{w_load_sign & w_ld_half[0]}}, w_ld_half};
        end
    end

    logic [0:31] w_wb_alu;
    logic [0:31] w_wb_data;

    assign w_wb_alu  = w_pc_to_reg ? w_next_pc : w_alu;
    assign w_wb_data = (!w_pc_to_reg && w_mem_to_reg) ? w_load : w_wb_alu;

    logic             w_stall;
    logic             w_issue;
    logic             w_done;
    logic             w_align_nxt;
    logic [0:OUT_W-1] w_memwb_nxt;

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_align_nxt  = 1'b0;
        w_memwb_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_misaligned) begin
                    w_align_nxt = 1'b1;
                    w_memwb_nxt = {w_wb_alu, w_dest, 1'b0, w_leap, w_leap_addr};
                end else if (w_memop) begin
                    w_stall      = 1'b1;
                    w_issue      = 1'b1;
                    w_next_state = S_REQ;
                end else begin
                    w_memwb_nxt = {w_wb_data, w_dest, w_reg_write, w_leap, w_leap_addr};
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                    w_memwb_nxt  = {w_wb_data, w_dest, w_reg_write, w_leap, w_leap_addr};
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    logic             r_req;
    logic             r_we;
    logic [0:31]      r_addr;
    logic [0:3]       r_be;
    logic [0:31]      r_wdata;
    logic             r_align_err;
    logic [0:OUT_W-1] r_memwb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_align_err <= 1'b0;
            r_memwb     <= '0;
        end else begin
            r_align_err <= w_align_nxt;
            r_memwb     <= w_memwb_nxt;
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= w_mem_write;
                r_addr  <= {w_alu[0:29], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end else if (w_done) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
            end
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign align_err  = r_align_err;
    assign memwb_out  = r_memwb;
    assign stall      = w_stall;

endmodule

// File: doc/mem_stage_ctl.md
Name: mem_stage_ctl

Overview:
MEM-stage controller that consumes the 142-bit EX/MEM bundle and drives a handshaked, variable-latency data memory. It performs loads and stores with byte, halfword and word sizes, aligns and sign- or zero-extends load data, and selects the write-back value. Results are registered into a packed MEM/WB bundle. The block stalls upstream stages while a memory access is outstanding.

Parameters:
IN_W, 142, EX/MEM bundle width
OUT_W, 71, MEM/WB bundle width

Ports:
clk  input  1  clock
reset  input  1  reset; asynchronous, active-high
exmem_in  input  [0:141]  EX/MEM bundle: nextPC[0:31] opB[32:63] destReg[64:68] aluResult[69:100] PCtoReg[101] RegToPC[102] RegWrite[103] MemToReg[104] MemWrite[105] loadSign[106] DSize[107:108] leapAddr[109:140] leap[141]
dmem_req  output  1  access request, registered
dmem_we  output  1  1 = store, registered
dmem_addr  output  [0:31]  word-aligned address (aluResult with bits 30:31 forced to 0), registered
dmem_be  output  [0:3]  byte enables; bit 0 = byte at offset 0 = data[0:7], registered
dmem_wdata  output  [0:31]  store data, lane-replicated, registered
dmem_rdata  input  [0:31]  load data, valid when dmem_ack=1
dmem_ack  input  1  one-cycle completion pulse
stall  output  1  combinational; holds the PC, IF/ID, ID/EX and EX/MEM registers
align_err  output  1  one-cycle pulse for a misaligned access, registered
memwb_out  output  [0:70]  writeData[0:31] destReg[32:36] RegWrite[37] leap[38] leapAddr[39:70], registered

Behaviour:
- memop = MemToReg | MemWrite. DSize: 00 byte, 01 half, 10/11 word. off = aluResult[99:100].
- misaligned = memop & ((half & off[1]) | (word & off != 0)).
- FSM has 2 states, IDLE and REQ. Reset enters IDLE.
- IDLE, memop & !misaligned:
  - stall=1.
  - Next edge: load dmem_req=1, dmem_we=MemWrite, addr, be and wdata; go to REQ.
  - memwb_out gets a bubble (RegWrite=0, leap=0, other fields 0).
- IDLE, misaligned: stall=0, no request issued. Next edge: align_err=1 and memwb_out captures the instruction with RegWrite forced to 0 and leap passed through.
- IDLE, !memop: stall=0. Next edge: memwb_out captures writeData, destReg, RegWrite, leap, leapAddr.
- REQ, dmem_ack=0: stall=1; dmem_* outputs held stable; memwb_out holds a bubble.
- REQ, dmem_ack=1: stall=0 in the same cycle. Next edge: dmem_req=0, memwb_out captures the result, state returns to IDLE. The EX/MEM register advances on the same edge, so a back-to-back memop restarts the IDLE->REQ sequence.
- Minimum access latency: 2 cycles in MEM (request cycle plus ack cycle with a zero-wait memory). Non-memory instructions take 1 cycle.
- dmem_ack while in IDLE is ignored.
- Enables: byte, be = one-hot at off. Half, be = 1100 (off 0) or 0011 (off 2). Word, be = 1111.
- Store wdata:
  - byte: opB[24:31] replicated 4 times
  - half: opB[16:31] replicated 2 times
  - word: opB
- Load extraction: the byte at offset o is rdata[8o:8o+7]; a half at off 0 is rdata[0:15], at off 2 is rdata[16:31]. If loadSign=1 the value is sign-extended to 32 bits, otherwise zero-extended.
- writeData priority: PCtoReg ? nextPC : MemToReg ? loadData : aluResult. A store writes writeData = aluResult with RegWrite as given (normally 0).
- Reset, including mid-access: asynchronous. All outputs go to 0 (dmem_req dropped, memwb_out bubble, align_err=0) and the FSM goes to IDLE. An outstanding ack arriving after reset is ignored.
- RegToPC does not affect this block.

Test Plan:
- ALU op, aluResult=0x0000_1234, RegWrite=1, destReg=5, memop=0 -> stall=0; next cycle memwb_out writeData=0x0000_1234, destReg=5, RegWrite=1.
- lb with loadSign=1 at addr 0x103, memory returns 0x1122_33F0 with ack after 3 wait cycles -> dmem_addr=0x100, be=0001; stall high for 4 cycles; writeData=0xFFFF_FFF0.
- lhu at addr 0x202 (loadSign=0), rdata=0xAAAA_8001, zero wait -> be=0011; writeData=0x0000_8001; total of 2 cycles in MEM.
- sb of opB=0x0000_00AB at addr 0x301 -> dmem_we=1, be=0100, wdata=0xABAB_ABAB; RegWrite=0 in memwb_out.
- lw at addr 0x402 -> no dmem_req; align_err pulses for 1 cycle; memwb RegWrite=0; stall stays 0.
- Assert reset while in REQ with ack pending -> dmem_req=0 and memwb_out=0 immediately; a late ack is ignored; state IDLE; the next ALU op passes normally.
